// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared defaults and reference decode function for the 2-to-4 decoder
package decoder_pkg;

  localparam int IN_W      = 2;
  localparam int MAX_IN_W  = 4;
  localparam int MAX_OUT_W = 2 ** MAX_IN_W;

  // Returns the widest one-hot; callers truncate to their own OUT_W.
  function automatic logic [MAX_OUT_W-1:0] onehot_decode(input logic [MAX_IN_W-1:0] sel,
                                                         input logic               en);
    logic [MAX_OUT_W-1:0] res;
    res = '0;
    if (en) begin
      res = MAX_OUT_W'(1) << sel;
    end
    return res;
  endfunction

endpackage

// File: rtl/decoder_2to4_bh_if.sv
// rtl/decoder_2to4_bh_if.sv - select/enable/result bundle for the registered decoder
interface decoder_2to4_bh_if #(
  parameter int IN_W  = decoder_pkg::IN_W,
  parameter int OUT_W = 2 ** IN_W
) (
  input logic clk
);

  logic [IN_W-1:0]  in;
  logic             en;
  logic [OUT_W-1:0] out;

  modport master (
    input  clk,
    output in,
    output en,
    input  out
  );

  modport slave (
    input  clk,
    input  in,
    input  en,
    output out
  );

endinterface

// File: rtl/decoder_core.sv
// rtl/decoder_core.sv - combinational binary-to-one-hot decode, zero when disabled
module decoder_core #(
  parameter int IN_W  = decoder_pkg::IN_W,
  parameter int OUT_W = 2 ** IN_W
) (
  input  logic [IN_W-1:0]  in,
  input  logic             en,
  output logic [OUT_W-1:0] dec
);

  // An X select propagates through the shift on purpose.
  always_comb begin
    dec = '0;
    case (en)
      1'b1:    dec = OUT_W'(1) << in;
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/decoder_2to4_bh.sv
// rtl/decoder_2to4_bh.sv - registered one-hot decoder with enable, sync reset and output polarity
module decoder_2to4_bh #(
  parameter int  IN_W           = decoder_pkg::IN_W,
  parameter bit  OUT_ACTIVE_LOW = 1'b0,
  localparam int OUT_W          = 2 ** IN_W
) (
  output logic [OUT_W-1:0] out,
  input  logic [IN_W-1:0]  in,
  input  logic             en,
  input  logic             clk,
  input  logic             rst
);

  localparam logic [OUT_W-1:0] INACTIVE = OUT_ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic [OUT_W-1:0] dec;

  decoder_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in  (in),
    .en  (en),
    .dec (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= INACTIVE;
    end else begin
      out <= dec ^ INACTIVE;
    end
  end

  // Each edge's result must equal the reference decode of the previous edge's inputs.
  property p_decode_invariant;
    @(posedge clk)
      1'b1 |=> (out == (OUT_W'(decoder_pkg::onehot_decode(
                           decoder_pkg::MAX_IN_W'($past(in)),
                           $past(en) & ~$past(rst))) ^ INACTIVE));
  endproperty

  a_decode_invariant: assert property (p_decode_invariant);

endmodule

// File: tb/tb_decoder_2to4_bh.sv
// tb/tb_decoder_2to4_bh.sv - self-checking bench for decoder_2to4_bh in both output polarities
module tb_decoder_2to4_bh;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] out_n;
  logic [3:0] hold;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  decoder_2to4_bh_if #(.IN_W(2)) bus (.clk(clk));

  decoder_2to4_bh #(
    .IN_W           (2),
    .OUT_ACTIVE_LOW (1'b0)
  ) dut (
    .out (bus.out),
    .in  (bus.in),
    .en  (bus.en),
    .clk (clk),
    .rst (rst)
  );

  decoder_2to4_bh #(
    .IN_W           (2),
    .OUT_ACTIVE_LOW (1'b1)
  ) dut_n (
    .out (out_n),
    .in  (bus.in),
    .en  (bus.en),
    .clk (clk),
    .rst (rst)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Line number `s` is high when enabled and out of reset: value 2 to the power s.
  function automatic logic [3:0] ref_decode(input logic r, input logic e, input logic [1:0] s);
    int v;
    v = 0;
    if (!r && e) begin
      v = 1;
      for (int k = 0; k < int'(s); k++) v = v * 2;
    end
    return 4'(v);
  endfunction

  task automatic apply(input logic r, input logic e, input logic [1:0] s, input string tag);
    logic [3:0] exp;
    @(negedge clk);
    rst    = r;
    bus.en = e;
    bus.in = s;
    exp    = ref_decode(r, e, s);
    @(posedge clk);
    #1;
    check(tag, bus.out, exp);
    check({tag, "_low"}, out_n, 4'(15 - int'(exp)));
    hold = exp;
  endtask

  initial begin
    bus.en = 1'b0;
    bus.in = 2'b00;

    apply(1'b1, 1'b1, 2'b11, "reset_edge0");
    apply(1'b1, 1'b1, 2'b11, "reset_edge1");
    apply(1'b0, 1'b1, 2'b11, "reset_release");

    for (int s = 0; s < 4; s++) apply(1'b0, 1'b1, 2'(s), $sformatf("en_sweep_%0d", s));
    for (int s = 0; s < 4; s++) apply(1'b0, 1'b0, 2'(s), $sformatf("dis_sweep_%0d", s));

    apply(1'b0, 1'b1, 2'b10, "toggle_on0");
    apply(1'b0, 1'b0, 2'b10, "toggle_off");
    apply(1'b0, 1'b1, 2'b10, "toggle_on1");

    bus.en = 1'b0;
    #1;
    check("midcycle_en", bus.out, hold);
    bus.in = 2'b01;
    #1;
    check("midcycle_in", bus.out, hold);
    bus.en = 1'b1;
    #1;
    check("midcycle_both", bus.out, hold);

    apply(1'b0, 1'b1, 2'b01, "midrst_pre");
    apply(1'b1, 1'b1, 2'b01, "midrst_hit");
    apply(1'b0, 1'b1, 2'b01, "midrst_post");

    for (int i = 0; i < 200; i++) begin
      apply(($urandom_range(0, 15) == 0), 1'($urandom), 2'($urandom), $sformatf("rand_%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
